// File: rtl/coin_return.sv
// Change-return sequencer: subtracts the item price from a settled nickel credit
// and pays the difference out as dimes then nickels through a req/ack ejector.
module coin_return #(
  parameter int PRICE_N     = 3,
  parameter int GAP         = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] credit_i,
  input  logic       coin_ack_i,
  output logic       eject_dime_o,
  output logic       eject_nickel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       short_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  // state    | meaning
  // ST_IDLE  | waiting for start_i
  // ST_CALC  | credit latched, subtract price
  // ST_DIME  | requesting one dime, waiting for ack
  // ST_NICK  | requesting one nickel, waiting for ack
  // ST_GAP   | idle spacing between ejections
  // ST_DONE  | change fully paid (one cycle)
  // ST_SHORT | credit below price (one cycle)
  // ST_FAULT | ejector timed out, held until reset
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_CALC  = 3'b001,
    ST_DIME  = 3'b010,
    ST_NICK  = 3'b011,
    ST_GAP   = 3'b100,
    ST_DONE  = 3'b101,
    ST_SHORT = 3'b110,
    ST_FAULT = 3'b111
  } state_t;

  localparam logic [3:0] PRICE_W  = 4'(PRICE_N);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] remain_q, remain_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] change;

  assign change = credit_q - PRICE_W;

  // Dimes first; a dime is only chosen when at least two nickels remain.
  function automatic state_t decide(input logic [3:0] r);
    if (r == 4'd0)      return ST_DONE;
    else if (r >= 4'd2) return ST_DIME;
    else                return ST_NICK;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      credit_q <= 4'd0;
      remain_q <= 4'd0;
      wait_q   <= 8'd0;
      gap_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      remain_q <= remain_d;
      wait_q   <= wait_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    remain_d = remain_q;
    wait_d   = wait_q;
    gap_d    = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          credit_d = credit_i;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (credit_q < PRICE_W) begin
          state_d = ST_SHORT;
        end else begin
          remain_d = change;
          state_d  = decide(change);
        end
      end
      ST_DIME, ST_NICK: begin
        // An ack on the final timeout edge still counts as a delivered coin.
        if (coin_ack_i) begin
          remain_d = remain_q - ((state_q == ST_DIME) ? 4'd2 : 4'd1);
          wait_d   = 8'd0;
          gap_d    = 4'd0;
          state_d  = ST_GAP;
        end else if (wait_q == ACK_LAST) begin
          wait_d  = 8'd0;
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = decide(remain_q);
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DONE, ST_SHORT: state_d = ST_IDLE;
      ST_FAULT:          state_d = ST_FAULT;
      default:           state_d = ST_IDLE;
    endcase
  end

  assign eject_dime_o   = (state_q == ST_DIME);
  assign eject_nickel_o = (state_q == ST_NICK);
  assign done_o         = (state_q == ST_DONE);
  assign short_o        = (state_q == ST_SHORT);
  assign fault_o        = (state_q == ST_FAULT);
  assign busy_o         = (state_q != ST_IDLE);
  assign state_o        = state_q;

endmodule

// File: doc/coin_return.md
# coin_return

Change-return sequencer for the vending machine. It accepts a settled credit count, measured in nickels, once a sale completes. It subtracts the item price and drives the coin ejector with dime and nickel eject requests, using a request/acknowledge handshake, until the change is paid. It sits downstream of the coin-accepting FSM and is the output side of the coin path: coins come in through the acceptor and go out through this block.

## Interface
Parameters:
- PRICE_N, 3: item price in nickels (15 cents).
- GAP, 2: idle cycles between ejections, range 1–15.
- ACK_TIMEOUT, 15: maximum cycles to wait for CoinAck, range 1–255.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  begin a return; sampled only in IDLE.
- Credit  input  4  credit in nickels, 0–15; captured on the Start edge.
- CoinAck  input  1  ejector has released the requested coin.
- EjectDime  output  1  request one dime.
- EjectNickel  output  1  request one nickel.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when change is fully paid.
- Short  output  1  one-cycle pulse when Credit < PRICE_N.
- Fault  output  1  ejector timeout; sticky until reset.
- State  output  3  current FSM state, for debug and bench.

## Operation
- Moore FSM with a 3-bit state register. Encoding:
  - IDLE=000, CALC=001, EJ_DIME=010, EJ_NICK=011
  - GAP=100, DONE=101, SHORT=110, FAULT=111
- Outputs are decoded from the state only:
  - EjectDime = EJ_DIME
  - EjectNickel = EJ_NICK
  - Done = DONE
  - Short = SHORT
  - Fault = FAULT
  - Busy = (State != IDLE)
- IDLE: when Start=1, latch Credit into a 4-bit credit register and go to CALC. Start in any other state is ignored.
- CALC: if credit < PRICE_N, go to SHORT. Otherwise load remain = credit − PRICE_N (4 bits, unsigned) and go to the decide step.
- Decide step (used on exit from CALC and from GAP):
  - remain == 0 → DONE
  - remain ≥ 2 → EJ_DIME
  - remain == 1 → EJ_NICK
  - Dimes are always paid first.
- EJ_DIME / EJ_NICK: hold the request. On an edge with CoinAck=1, decrement remain by 2 (dime) or 1 (nickel), clear the wait counter, and go to GAP.
- Wait counter (8 bits): counts edges spent in an EJ state. If ACK_TIMEOUT edges pass with no CoinAck, go to FAULT. If CoinAck arrives on that same final edge, the acknowledge wins.
- GAP: both eject outputs low for GAP cycles, then run the decide step.
- DONE and SHORT: one cycle each, then IDLE.
- FAULT: held until Reset=0. Start and CoinAck are ignored.
- CoinAck outside the EJ states is ignored and has no side effects.
- Remain can never underflow: a dime is only requested when remain ≥ 2.

## Timing
- Reset=0 sampled at an edge: State=IDLE, credit=0, remain=0, counters=0. All outputs are 0 from the following cycle, whatever else is happening, including mid-ejection or in FAULT.
- Start sampled at edge T:
  - State=CALC after T.
  - DONE, SHORT or the first EJ state after T+1.
- Minimum latency from Start to Done with no change due: 2 edges. Done is high during the cycle after edge T+1.
- Each ejection from its EJ state back to the next decide:
  - 1 edge for the CoinAck plus GAP edges in GAP.
  - With GAP=2 and CoinAck arriving the first cycle: 1 cycle in EJ + 2 cycles in GAP, then the next EJ.
- An eject request is held high continuously until the acknowledge edge. It drops in the cycle after that edge.
- Back-to-back sales: a new Start is accepted on the first edge with State=IDLE, i.e. the cycle after DONE or SHORT.

## Test plan
- Credit=5, Start, CoinAck one cycle after each request → exactly one EjectDime, then Done. State sequence 001, 010, 100, 100, 101, 000.
- Credit=6, immediate CoinAck → EjectDime, GAP×2, EjectNickel, GAP×2, then Done. Total 0 coins outstanding; Short never asserted.
- Credit=3 → Done pulse in the cycle after edge T+1, no eject outputs. Credit=2 → Short pulse at the same time, no Done.
- Credit=15 (remain=12) → six EjectDime requests and zero EjectNickel. CoinAck delayed 5 cycles each; request stays high throughout each delay.
- Credit=5, CoinAck never given → EjectDime high for exactly 15 cycles, then Fault=1 and State=111 held. A Start while in FAULT is ignored; Reset=0 clears to IDLE.
- Reset=0 during EJ_NICK with remain=1 → all outputs 0 next cycle. A following Credit=4 sale pays exactly one nickel.
